// File: rtl/dm_responder.sv
// Data-memory responder: word-addressed RAM with byte-lane writes and a combinational read port,
// plus a first-word-fall-through log of every committed store for a downstream trace checker.
module dm_responder #(
    parameter int DEPTH_WORDS = 3072,
    parameter int LOG_DEPTH   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  m_data_addr,
    input  logic [31:0]                  m_data_wdata,
    input  logic [3:0]                   m_data_byteen,
    input  logic [31:0]                  m_inst_addr,
    output logic [31:0]                  m_data_rdata,
    output logic                         log_valid,
    input  logic                         log_ready,
    output logic [31:0]                  log_pc,
    output logic [31:0]                  log_addr,
    output logic [31:0]                  log_data,
    output logic [3:0]                   log_byteen,
    output logic [$clog2(LOG_DEPTH):0]   log_count,
    output logic [31:0]                  log_drops,
    output logic                         addr_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(LOG_DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(LOG_DEPTH);

    // Words are only trusted once written since reset; this gives a one-cycle
    // clear of the whole array without needing a reset on the storage itself.
    logic [31:0]            mem [DEPTH_WORDS];
    logic [DEPTH_WORDS-1:0] word_valid;

    logic [29:0]   index;
    logic [AW-1:0] widx;
    logic          in_range;
    logic          wr_en;
    logic [31:0]   cur_word;
    logic [31:0]   merged;

    assign index    = m_data_addr[31:2];
    assign widx     = index[AW-1:0];
    assign in_range = (index < 30'(DEPTH_WORDS));
    assign wr_en    = in_range && (m_data_byteen != 4'b0000);
    assign cur_word = (in_range && word_valid[widx]) ? mem[widx] : 32'h0;

    assign m_data_rdata = cur_word;

    always_comb begin
        merged = cur_word;
        for (int i = 0; i < 4; i++) begin
            if (m_data_byteen[i]) merged[8*i +: 8] = m_data_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_valid <= '0;
        end else if (wr_en) begin
            word_valid[widx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            mem[widx] <= merged;
        end
    end

    logic [31:0]   fifo_pc     [LOG_DEPTH];
    logic [31:0]   fifo_addr   [LOG_DEPTH];
    logic [31:0]   fifo_data   [LOG_DEPTH];
    logic [3:0]    fifo_byteen [LOG_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          pop;
    logic          accept;

    assign full   = (log_count == FULL_COUNT);
    assign pop    = log_valid && log_ready;
    // When full, a same-edge pop frees the head slot, which is exactly where wr_ptr points.
    assign accept = wr_en && (!full || pop);

    assign log_valid  = (log_count != '0);
    assign log_pc     = log_valid ? fifo_pc[rd_ptr]     : 32'h0;
    assign log_addr   = log_valid ? fifo_addr[rd_ptr]   : 32'h0;
    assign log_data   = log_valid ? fifo_data[rd_ptr]   : 32'h0;
    assign log_byteen = log_valid ? fifo_byteen[rd_ptr] : 4'h0;

    always_ff @(posedge clk) begin
        if (reset && accept) begin
            fifo_pc[wr_ptr]     <= m_inst_addr;
            fifo_addr[wr_ptr]   <= {m_data_addr[31:2], 2'b00};
            fifo_data[wr_ptr]   <= merged;
            fifo_byteen[wr_ptr] <= m_data_byteen;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            log_count <= '0;
            log_drops <= 32'h0;
            addr_err  <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   log_count <= log_count + 1'b1;
                2'b01:   log_count <= log_count - 1'b1;
                default: log_count <= log_count;
            endcase
            if (wr_en && !accept && (log_drops != 32'hFFFF_FFFF)) begin
                log_drops <= log_drops + 32'h1;
            end
            if (!in_range && (m_data_byteen != 4'b0000)) begin
                addr_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: directed scenarios plus randomized traffic checked against
// an array-and-queue reference model of the memory and write log.
module tb_dm_responder;

    localparam int DEPTH     = 3072;
    localparam int LOG_DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] m_data_addr = '0;
    logic [31:0] m_data_wdata = '0;
    logic [3:0]  m_data_byteen = '0;
    logic [31:0] m_inst_addr = '0;
    logic [31:0] m_data_rdata;
    logic        log_valid;
    logic        log_ready = 1'b0;
    logic [31:0] log_pc, log_addr, log_data, log_drops;
    logic [3:0]  log_byteen;
    logic [3:0]  log_count;
    logic        addr_err;

    dm_responder #(.DEPTH_WORDS(DEPTH), .LOG_DEPTH(LOG_DEPTH)) dut (
        .clk(clk), .reset(reset),
        .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
        .m_data_byteen(m_data_byteen), .m_inst_addr(m_inst_addr),
        .m_data_rdata(m_data_rdata),
        .log_valid(log_valid), .log_ready(log_ready),
        .log_pc(log_pc), .log_addr(log_addr), .log_data(log_data),
        .log_byteen(log_byteen), .log_count(log_count),
        .log_drops(log_drops), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } entry_t;

    logic [31:0] ref_mem [DEPTH];
    entry_t      ref_q[$];
    logic [31:0] ref_drops;
    logic        ref_err;

    int checks = 0;
    int errors = 0;

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        ref_q.delete();
        ref_drops = 32'h0;
        ref_err   = 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int unsigned idx;
        idx = a[31:2];
        return (idx < DEPTH) ? ref_mem[idx] : 32'h0;
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                         input logic [31:0] pc, input logic rdy);
        m_data_addr   = a;
        m_data_wdata  = wd;
        m_data_byteen = be;
        m_inst_addr   = pc;
        log_ready     = rdy;
        #1;
    endtask

    // Advance one rising edge and apply the architectural effect of the inputs held across it.
    task automatic tick();
        int unsigned idx;
        logic        do_pop;
        logic [31:0] nw;
        entry_t      e;
        @(posedge clk);
        idx    = m_data_addr[31:2];
        do_pop = (ref_q.size() != 0) && log_ready;
        if (do_pop) void'(ref_q.pop_front());
        if (m_data_byteen != 4'b0000) begin
            if (idx >= DEPTH) begin
                ref_err = 1'b1;
            end else begin
                nw = ref_mem[idx];
                for (int i = 0; i < 4; i++)
                    if (m_data_byteen[i]) nw[8*i +: 8] = m_data_wdata[8*i +: 8];
                ref_mem[idx] = nw;
                e.pc   = m_inst_addr;
                e.addr = {m_data_addr[31:2], 2'b00};
                e.data = nw;
                e.be   = m_data_byteen;
                if (ref_q.size() < LOG_DEPTH) ref_q.push_back(e);
                else if (ref_drops != 32'hFFFF_FFFF) ref_drops = ref_drops + 1;
            end
        end
        #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 2*LOG_DEPTH && ref_q.size() != 0; n++) begin
            drive(32'h0, 32'h0, 4'h0, 32'h0, 1'b1);
            tick();
        end
        drive(32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
        checks++;
        if (log_count !== 4'd0) begin
            errors++;
            $display("FAIL drain_empty: log_count=%0d required=0", log_count);
        end
    endtask

    task automatic test_reset();
        model_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        drive(32'h10, 32'h0, 4'h0, 32'h0, 1'b0);
        checks++;
        if (log_valid !== 1'b0 || log_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_fifo: valid=%0b count=%0d required 0/0", log_valid, log_count);
        end
        checks++;
        if (log_drops !== 32'h0 || addr_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: drops=%0d err=%0b required 0/0", log_drops, addr_err);
        end
        checks++;
        if (m_data_rdata !== 32'h0 || log_pc !== 32'h0 || log_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h pc=%h data=%h required 0", m_data_rdata, log_pc, log_data);
        end
    endtask

    task automatic test_full_word();
        drive(32'h10, 32'h1234_5678, 4'hF, 32'h400, 1'b0);
        checks++;
        if (m_data_rdata !== 32'h0) begin
            errors++;
            $display("FAIL fw_prewrite: rdata=%h required=%h", m_data_rdata, 32'h0);
        end
        tick();
        drive(32'h10, 32'h0, 4'h0, 32'h0, 1'b0);
        checks++;
        if (m_data_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL fw_readback: rdata=%h required=%h", m_data_rdata, 32'h1234_5678);
        end
        checks++;
        if (log_valid !== 1'b1 || log_pc !== 32'h400 || log_addr !== 32'h10 ||
            log_data !== 32'h1234_5678 || log_byteen !== 4'hF || log_count !== 4'd1) begin
            errors++;
            $display("FAIL fw_log: valid=%0b pc=%h addr=%h data=%h be=%h count=%0d required 1/400/10/12345678/f/1",
                     log_valid, log_pc, log_addr, log_data, log_byteen, log_count);
        end
        drain();
    endtask

    task automatic test_byte_merge();
        drive(32'h20, 32'h1122_3344, 4'hF, 32'h500, 1'b0);
        tick();
        drive(32'h23, 32'hAABB_CCDD, 4'b0101, 32'h504, 1'b0);
        tick();
        drive(32'h20, 32'h0, 4'h0, 32'h0, 1'b1);
        checks++;
        if (m_data_rdata !== 32'h11BB_33DD) begin
            errors++;
            $display("FAIL merge_read: rdata=%h required=%h", m_data_rdata, 32'h11BB_33DD);
        end
        tick();
        drive(32'h20, 32'h0, 4'h0, 32'h0, 1'b0);
        checks++;
        if (log_byteen !== 4'b0101 || log_data !== 32'h11BB_33DD || log_addr !== 32'h20 || log_pc !== 32'h504) begin
            errors++;
            $display("FAIL merge_log: be=%b data=%h addr=%h pc=%h required 0101/11bb33dd/20/504",
                     log_byteen, log_data, log_addr, log_pc);
        end
        drain();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 10; i++) begin
            drive(32'h100 + 32'(4*i), 32'hA000_0000 + 32'(i), 4'hF, 32'h1000 + 32'(4*i), 1'b0);
            tick();
        end
        drive(32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
        checks++;
        if (log_count !== 4'd8 || log_drops !== 32'd2) begin
            errors++;
            $display("FAIL ovf_counts: count=%0d drops=%0d required 8/2", log_count, log_drops);
        end
        for (int i = 0; i < 10; i++) begin
            drive(32'h100 + 32'(4*i), 32'h0, 4'h0, 32'h0, 1'b0);
            checks++;
            if (m_data_rdata !== 32'hA000_0000 + 32'(i)) begin
                errors++;
                $display("FAIL ovf_mem[%0d]: rdata=%h required=%h", i, m_data_rdata, 32'hA000_0000 + 32'(i));
            end
        end
        for (int i = 0; i < 8; i++) begin
            drive(32'h0, 32'h0, 4'h0, 32'h0, 1'b1);
            checks++;
            if (log_pc !== 32'h1000 + 32'(4*i) || log_data !== 32'hA000_0000 + 32'(i)) begin
                errors++;
                $display("FAIL ovf_order[%0d]: pc=%h data=%h required %h/%h", i, log_pc, log_data,
                         32'h1000 + 32'(4*i), 32'hA000_0000 + 32'(i));
            end
            tick();
        end
        checks++;
        if (log_count !== 4'd0 || log_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_drained: count=%0d valid=%0b required 0/0", log_count, log_valid);
        end
        drive(32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp_pc;
        for (int i = 0; i < 8; i++) begin
            drive(32'h200 + 32'(4*i), 32'hB000_0000 + 32'(i), 4'hF, 32'h2000 + 32'(4*i), 1'b0);
            tick();
        end
        drive(32'h240, 32'hC0DE_0001, 4'hF, 32'h2ABC, 1'b1);
        tick();
        drive(32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
        checks++;
        if (log_count !== 4'd8 || log_drops !== 32'd2) begin
            errors++;
            $display("FAIL fpp_counts: count=%0d drops=%0d required 8/2", log_count, log_drops);
        end
        for (int i = 0; i < 8; i++) begin
            exp_pc = (i < 7) ? 32'h2000 + 32'(4*(i+1)) : 32'h2ABC;
            drive(32'h0, 32'h0, 4'h0, 32'h0, 1'b1);
            checks++;
            if (log_pc !== exp_pc) begin
                errors++;
                $display("FAIL fpp_order[%0d]: pc=%h required=%h", i, log_pc, exp_pc);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_out_of_range();
        drive(32'h3000, 32'hDEAD_BEEF, 4'hF, 32'h3333, 1'b0);
        checks++;
        if (m_data_rdata !== 32'h0) begin
            errors++;
            $display("FAIL oor_read: rdata=%h required=0", m_data_rdata);
        end
        tick();
        drive(32'h3000, 32'h0, 4'h0, 32'h0, 1'b0);
        checks++;
        if (addr_err !== 1'b1 || log_valid !== 1'b0 || log_count !== 4'd0 || m_data_rdata !== 32'h0) begin
            errors++;
            $display("FAIL oor_write: err=%0b valid=%0b count=%0d rdata=%h required 1/0/0/0",
                     addr_err, log_valid, log_count, m_data_rdata);
        end
        drive(32'h10, 32'h0, 4'h0, 32'h0, 1'b0);
        checks++;
        if (m_data_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL oor_mem_intact: rdata=%h required=%h", m_data_rdata, 32'h1234_5678);
        end
        for (int i = 0; i < 5; i++) begin
            drive(32'h300 + 32'(4*i), 32'(i), 4'hF, 32'h3000 + 32'(i), 1'b1);
            tick();
        end
        drive(32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
        checks++;
        if (addr_err !== 1'b1) begin
            errors++;
            $display("FAIL oor_sticky: err=%0b required=1", addr_err);
        end
        drain();
    endtask

    task automatic test_random();
        logic [29:0] idx;
        logic [31:0] a;
        logic [3:0]  be;
        entry_t      h;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0:       idx = 30'(DEPTH + $urandom_range(0, 8));
                1:       idx = 30'($urandom_range(0, DEPTH-1));
                default: idx = 30'($urandom_range(0, 63));
            endcase
            a  = {idx, 2'($urandom)};
            be = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            drive(a, $urandom, be, $urandom, 1'($urandom));
            checks++;
            if (m_data_rdata !== model_read(a)) begin
                errors++;
                $display("FAIL rnd_rdata[%0d]: addr=%h rdata=%h required=%h", n, a, m_data_rdata, model_read(a));
            end
            if (ref_q.size() != 0) begin
                h = ref_q[0];
            end else begin
                h.pc = 0; h.addr = 0; h.data = 0; h.be = 0;
            end
            checks++;
            if (log_valid !== (ref_q.size() != 0) || log_count !== 4'(ref_q.size()) ||
                log_pc !== h.pc || log_addr !== h.addr || log_data !== h.data || log_byteen !== h.be) begin
                errors++;
                $display("FAIL rnd_head[%0d]: valid=%0b count=%0d pc=%h addr=%h data=%h be=%h required %0d/%h/%h/%h/%h",
                         n, log_valid, log_count, log_pc, log_addr, log_data, log_byteen,
                         ref_q.size(), h.pc, h.addr, h.data, h.be);
            end
            tick();
        end
        drive(32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
        checks++;
        if (log_drops !== ref_drops || addr_err !== ref_err) begin
            errors++;
            $display("FAIL rnd_flags: drops=%0d err=%0b required %0d/%0b", log_drops, addr_err, ref_drops, ref_err);
        end
        drain();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            drive(32'h10 + 32'(4*i), 32'h5500_0000 + 32'(i), 4'hF, 32'h6000 + 32'(i), 1'b0);
            tick();
        end
        drive(32'h4000, 32'h1, 4'h1, 32'h0, 1'b0);
        tick();
        drive(32'h10, 32'hCAFE_F00D, 4'hF, 32'h7000, 1'b0);
        checks++;
        if (log_count !== 4'd3 || addr_err !== 1'b1) begin
            errors++;
            $display("FAIL ar_setup: count=%0d err=%0b required 3/1", log_count, addr_err);
        end
        #2 reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if (log_valid !== 1'b0 || log_count !== 4'd0 || log_drops !== 32'h0 || addr_err !== 1'b0) begin
            errors++;
            $display("FAIL ar_immediate: valid=%0b count=%0d drops=%0d err=%0b required all 0",
                     log_valid, log_count, log_drops, addr_err);
        end
        checks++;
        if (m_data_rdata !== 32'h0 || log_pc !== 32'h0) begin
            errors++;
            $display("FAIL ar_rdata: rdata=%h pc=%h required 0/0", m_data_rdata, log_pc);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (m_data_rdata !== 32'h0 || log_count !== 4'd0) begin
            errors++;
            $display("FAIL ar_ignored: rdata=%h count=%0d required 0/0", m_data_rdata, log_count);
        end
        reset = 1'b1;
        drive(32'h14, 32'h0000_00EE, 4'b0001, 32'h8000, 1'b0);
        tick();
        drive(32'h14, 32'h0, 4'h0, 32'h0, 1'b0);
        checks++;
        if (m_data_rdata !== 32'h0000_00EE || log_count !== 4'd1 || log_pc !== 32'h8000) begin
            errors++;
            $display("FAIL ar_resume: rdata=%h count=%0d pc=%h required 000000ee/1/8000",
                     m_data_rdata, log_count, log_pc);
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_byte_merge();
        test_overflow();
        test_full_push_pop();
        test_out_of_range();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder: the memory-side end of the CPU data interface (m_data_addr / m_data_wdata / m_data_byteen out of the core, m_data_rdata back into it).
- Implements a word-addressed RAM with byte-lane writes and same-cycle reads, as the core's pipeline requires.
- Also runs a write-log FIFO. Each committed store is exposed to a downstream trace checker over a valid/ready handshake.

Parameters:
- DEPTH_WORDS, 3072, number of 32-bit words in the array; valid byte addresses are 0 .. DEPTH_WORDS*4-1.
- LOG_DEPTH, 8, write-log FIFO entries; must be a power of 2, at least 2.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- m_data_addr  input  32  byte address from the core.
- m_data_wdata  input  32  store data, already lane-aligned by the core.
- m_data_byteen  input  4  byte-lane write enables; 4'b0000 means no write.
- m_inst_addr  input  32  PC of the instruction in the memory stage.
- m_data_rdata  output  32  read word at the word address of m_data_addr.
- log_valid  output  1  head FIFO entry is valid.
- log_ready  input  1  consumer accepts the head entry.
- log_pc  output  32  head entry: PC of the store.
- log_addr  output  32  head entry: word-aligned byte address.
- log_data  output  32  head entry: full word after the merge.
- log_byteen  output  4  head entry: lanes written.
- log_count  output  $clog2(LOG_DEPTH)+1  FIFO occupancy.
- log_drops  output  32  stores lost because the FIFO was full.
- addr_err  output  1  sticky out-of-range access flag.

Behaviour:
- Index is m_data_addr[31:2]. The access is in range iff the index is below DEPTH_WORDS. m_data_addr[1:0] is ignored.
- Read path is combinational.
  - m_data_rdata = mem[index] when in range, else 32'h0.
  - During a write cycle it returns the pre-write value; the new value is visible the cycle after the edge.
- Write happens at the rising edge when m_data_byteen != 0 and the access is in range.
  - For each lane i with byteen[i]=1: mem[index][8i+7:8i] <= m_data_wdata[8i+7:8i]. Other lanes are unchanged.
  - Non-contiguous enables (e.g. 4'b0101) are legal.
- Out-of-range access:
  - A read (byteen=0) that is out of range returns 0.
  - At the edge, addr_err is set when byteen != 0 and the access is out of range. An out-of-range read does not set it.
  - An out-of-range write leaves memory unchanged and is not logged.
  - addr_err stays 1 until reset.
- Log push happens on the same edge as every in-range write. The entry is {m_inst_addr, {m_data_addr[31:2],2'b00}, merged word, m_data_byteen}.
- FIFO is first-word-fall-through.
  - log_valid = (log_count != 0).
  - The log_* fields show the head entry while valid, and are 0 when empty.
- Pop occurs at the edge when log_valid && log_ready. log_ready while empty has no effect.
- Simultaneous push and pop:
  - Count is unchanged.
  - When full, the pop frees the slot and the push is accepted, with no drop.
- Push when full without a pop: the entry is discarded, the memory write still commits, and log_drops increments. log_drops saturates at 32'hFFFF_FFFF.
- Pointers wrap modulo LOG_DEPTH. log_count ranges 0..LOG_DEPTH.
- Reset (reset=0, asynchronous):
  - All array words are cleared to 0.
  - FIFO pointers, log_count, log_drops and addr_err are cleared to 0.
  - Outputs are log_valid=0 and all log_* = 0. m_data_rdata = 0 for any address.
  - Reset asserted mid-traffic aborts the in-flight write; no partial lane update is kept.
  - Inputs are ignored while reset=0. Operation resumes on the first rising edge after release.
- Latency: a store is logged and visible at the FIFO head 1 cycle after its write edge, when the FIFO was empty.

Test Plan:
- Full-word store and read-back.
  - Write addr=0x10, wdata=0x12345678, byteen=4'b1111.
  - Same cycle: rdata=0x0. Next cycle with addr=0x10: rdata=0x12345678, log_valid=1, log_pc=m_inst_addr, log_addr=0x10, log_data=0x12345678.
- Byte-lane merge.
  - Preload 0x11223344 at 0x20, then write wdata=0xAABBCCDD with byteen=4'b0101.
  - Read returns 0x11BB33DD; log_byteen=4'b0101 and log_data=0x11BB33DD.
- FIFO overflow.
  - Hold log_ready=0 and issue 10 stores with LOG_DEPTH=8.
  - Result: log_count=8, log_drops=2, all 10 memory words updated. Then raise log_ready: 8 entries pop in order and log_count reaches 0.
- Full with simultaneous push and pop.
  - At count=8, store while log_ready=1.
  - count stays 8, drops unchanged, and the new entry appears last.
- Out-of-range access.
  - Write addr=DEPTH_WORDS*4 (0x3000), byteen=4'b1111.
  - addr_err=1, no log entry, memory unchanged, read at 0x3000 returns 0.
  - addr_err stays 1 after 5 more in-range accesses.
- Asynchronous reset mid-operation.
  - With 3 entries queued and addr_err=1, pull reset low between clock edges.
  - Immediately: log_valid=0, log_count=0, log_drops=0, addr_err=0, and rdata=0 at 0x10.
